// File: rtl/tlk2711_pkg.sv
// Shared types and constants for the TLK2711 lane link sequencer.
package tlk2711_pkg;

    // Sequencer states; the encoding is visible on o_state.
    typedef enum logic [2:0] {
        StIdle  = 3'd0,
        StPwrup = 3'd1,
        StLock  = 3'd2,
        StSync  = 3'd3,
        StRun   = 3'd4,
        StStop  = 3'd5
    } link_state_e;

    // Test-mode encodings on i_mode; 3..7 are reserved and rejected.
    localparam logic [2:0] MODE_NORMAL = 3'd0;
    localparam logic [2:0] MODE_LOOP   = 3'd1;
    localparam logic [2:0] MODE_PRBS   = 3'd2;

    // Idle comma character carried on the RX word LSB.
    localparam logic [7:0] K28_5 = 8'hBC;

    // Default timing, in core clock cycles.
    localparam int unsigned DEF_PWR_WAIT     = 8;
    localparam int unsigned DEF_LOCK_WAIT    = 16;
    localparam int unsigned DEF_SYNC_CNT     = 4;
    localparam int unsigned DEF_SYNC_TIMEOUT = 64;
    localparam int unsigned DEF_DRAIN_CNT    = 16;

    // Counter width: log2 of the largest timing constant, plus one.
    function automatic int unsigned cnt_width(input int unsigned a, input int unsigned b,
                                              input int unsigned c, input int unsigned d,
                                              input int unsigned e);
        int unsigned m;
        m = a;
        if (b > m) m = b;
        if (c > m) m = c;
        if (d > m) m = d;
        if (e > m) m = e;
        return $clog2(m) + 1;
    endfunction

endpackage

// File: rtl/tlk2711_comma_sync.sv
// Comma qualification for SYNC: counts consecutive K28.5 cycles and total SYNC cycles.
// Both counters are held at zero while clear is high and saturate rather than wrap.
module tlk2711_comma_sync
    import tlk2711_pkg::*;
#(
    parameter int unsigned SYNC_CNT     = DEF_SYNC_CNT,
    parameter int unsigned SYNC_TIMEOUT = DEF_SYNC_TIMEOUT,
    parameter int unsigned CW           = 7
) (
    input  logic clk,
    input  logic rst,
    input  logic clear,
    input  logic i_rx_comma,
    output logic synced,
    output logic timeout
);

    localparam logic [CW-1:0] CNT_MAX  = '1;
    localparam logic [CW-1:0] SYNC_LIM = CW'(SYNC_CNT);
    // Timeout fires in the last allowed SYNC cycle so the state exits after exactly SYNC_TIMEOUT.
    localparam logic [CW-1:0] TMO_LIM  = CW'(SYNC_TIMEOUT - 1);

    logic [CW-1:0] comma_cnt;
    logic [CW-1:0] tmo_cnt;

    // Consecutive-comma run length; any non-comma cycle restarts the run.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            comma_cnt <= '0;
        end else if (clear || !i_rx_comma) begin
            comma_cnt <= '0;
        end else if (comma_cnt != CNT_MAX) begin
            comma_cnt <= comma_cnt + 1'b1;
        end
    end

    // Cycles spent searching for sync since the counters were last cleared.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            tmo_cnt <= '0;
        end else if (clear) begin
            tmo_cnt <= '0;
        end else if (tmo_cnt != CNT_MAX) begin
            tmo_cnt <= tmo_cnt + 1'b1;
        end
    end

    assign synced  = (comma_cnt >= SYNC_LIM);
    assign timeout = (tmo_cnt >= TMO_LIM);

endmodule

// File: rtl/tlk2711_link_ctrl.sv
// TLK2711 lane link sequencer: power-up, lock release, test-mode setup, comma
// qualification, TX source select and drained stop with acknowledge.
// Optional feature macro: TLK2711_LINK_RETRY_CNT_EN adds o_retry_cnt[7:0], a
// saturating count of SYNC timeouts cleared by each accepted start.
module tlk2711_link_ctrl
    import tlk2711_pkg::*;
#(
    parameter int unsigned PWR_WAIT     = DEF_PWR_WAIT,
    parameter int unsigned LOCK_WAIT    = DEF_LOCK_WAIT,
    parameter int unsigned SYNC_CNT     = DEF_SYNC_CNT,
    parameter int unsigned SYNC_TIMEOUT = DEF_SYNC_TIMEOUT,
    parameter int unsigned DRAIN_CNT    = DEF_DRAIN_CNT
) (
    input  logic       clk,
    input  logic       rst,
    input  logic       i_start,
    input  logic       i_stop,
    input  logic [2:0] i_mode,
    input  logic       i_rx_comma,
    output logic       o_enable,
    output logic       o_lckrefn,
    output logic       o_loopen,
    output logic       o_prbsen,
    output logic       o_testen,
    output logic       o_tx_sel,
    output logic       o_link_up,
    output logic       o_busy,
    output logic       o_err,
    output logic       o_stop_ack,
`ifdef TLK2711_LINK_RETRY_CNT_EN
    output logic [7:0] o_retry_cnt,
`endif
    output logic [2:0] o_state
);

    localparam int unsigned CW = cnt_width(PWR_WAIT, LOCK_WAIT, SYNC_CNT, SYNC_TIMEOUT,
                                           DRAIN_CNT);
    localparam logic [CW-1:0] PWR_LAST   = CW'(PWR_WAIT - 1);
    localparam logic [CW-1:0] LOCK_LAST  = CW'(LOCK_WAIT - 1);
    localparam logic [CW-1:0] DRAIN_LAST = CW'(DRAIN_CNT - 1);

    link_state_e   state_q, state_d;
    logic [CW-1:0] tmr_q, tmr_d;
    logic [2:0]    mode_q, mode_d;
    logic          err_d, ack_d;
    logic          en_d, lck_d, loop_d, prbs_d, tx_d, link_d, busy_d;

    logic start_q, start_prev, stop_q, stop_prev;
    logic start_edge, stop_edge;
    logic synced, timeout;

    // Register the request levels once more to find their rising edges.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            start_q    <= 1'b0;
            start_prev <= 1'b0;
            stop_q     <= 1'b0;
            stop_prev  <= 1'b0;
        end else begin
            start_q    <= i_start;
            start_prev <= start_q;
            stop_q     <= i_stop;
            stop_prev  <= stop_q;
        end
    end

    assign start_edge = start_q & ~start_prev;
    assign stop_edge  = stop_q & ~stop_prev;

    tlk2711_comma_sync #(
        .SYNC_CNT     (SYNC_CNT),
        .SYNC_TIMEOUT (SYNC_TIMEOUT),
        .CW           (CW)
    ) u_comma_sync (
        .clk        (clk),
        .rst        (rst),
        .clear      (state_q != StSync),
        .i_rx_comma (i_rx_comma),
        .synced     (synced),
        .timeout    (timeout)
    );

    // Next state, state timer and the output values that go with the next state.
    always_comb begin
        state_d = state_q;
        tmr_d   = (tmr_q != '1) ? tmr_q + 1'b1 : tmr_q;
        mode_d  = mode_q;
        err_d   = 1'b0;
        ack_d   = 1'b0;

        case (state_q)
            StIdle: begin
                // Stop wins over a coincident start.
                if (stop_edge) begin
                    ack_d = 1'b1;
                end else if (start_edge) begin
                    if (i_mode <= MODE_PRBS) begin
                        state_d = StPwrup;
                        mode_d  = i_mode;
                    end else begin
                        err_d = 1'b1;
                    end
                end
            end
            StPwrup: begin
                if (stop_edge)                 state_d = StStop;
                else if (tmr_q == PWR_LAST)    state_d = StLock;
            end
            StLock: begin
                if (stop_edge) begin
                    state_d = StStop;
                end else if (tmr_q == LOCK_LAST) begin
                    // PRBS has no comma stream to qualify on.
                    state_d = (mode_q == MODE_PRBS) ? StRun : StSync;
                end
            end
            StSync: begin
                if (stop_edge) begin
                    state_d = StStop;
                end else if (synced) begin
                    state_d = StRun;
                end else if (timeout) begin
                    state_d = StLock;
                    err_d   = 1'b1;
                end
            end
            StRun: begin
                if (stop_edge) state_d = StStop;
            end
            StStop: begin
                if (tmr_q == DRAIN_LAST) state_d = StIdle;
            end
            default: state_d = StIdle;
        endcase

        if (state_d != state_q) tmr_d = '0;
        // Acknowledge coincides with the final drain cycle.
        if (state_d == StStop && tmr_d == DRAIN_LAST) ack_d = 1'b1;

        en_d   = o_enable;
        lck_d  = o_lckrefn;
        loop_d = o_loopen;
        prbs_d = o_prbsen;
        case (state_d)
            StIdle: begin
                en_d   = 1'b0;
                lck_d  = 1'b0;
                loop_d = 1'b0;
                prbs_d = 1'b0;
            end
            StPwrup: begin
                en_d   = 1'b1;
                lck_d  = 1'b0;
                loop_d = 1'b0;
                prbs_d = 1'b0;
            end
            StLock, StSync, StRun: begin
                en_d   = 1'b1;
                lck_d  = 1'b1;
                loop_d = (mode_d == MODE_LOOP);
                prbs_d = (mode_d == MODE_PRBS);
            end
            default: ;  // STOP holds the device pins while draining
        endcase

        tx_d   = (state_d == StRun) && (mode_d != MODE_PRBS);
        link_d = (state_d == StRun);
        busy_d = (state_d != StIdle);
    end

    // State, timer, latched mode and all registered outputs.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q    <= StIdle;
            tmr_q      <= '0;
            mode_q     <= MODE_NORMAL;
            o_enable   <= 1'b0;
            o_lckrefn  <= 1'b0;
            o_loopen   <= 1'b0;
            o_prbsen   <= 1'b0;
            o_tx_sel   <= 1'b0;
            o_link_up  <= 1'b0;
            o_busy     <= 1'b0;
            o_err      <= 1'b0;
            o_stop_ack <= 1'b0;
        end else begin
            state_q    <= state_d;
            tmr_q      <= tmr_d;
            mode_q     <= mode_d;
            o_enable   <= en_d;
            o_lckrefn  <= lck_d;
            o_loopen   <= loop_d;
            o_prbsen   <= prbs_d;
            o_tx_sel   <= tx_d;
            o_link_up  <= link_d;
            o_busy     <= busy_d;
            o_err      <= err_d;
            o_stop_ack <= ack_d;
        end
    end

    assign o_state  = state_q;
    assign o_testen = 1'b0;

`ifdef TLK2711_LINK_RETRY_CNT_EN
    logic [7:0] retry_q;

    // Saturating SYNC-timeout count, restarted by every accepted start.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            retry_q <= 8'd0;
        end else if (state_q == StIdle && state_d == StPwrup) begin
            retry_q <= 8'd0;
        end else if (state_q == StSync && state_d == StLock && retry_q != 8'hFF) begin
            retry_q <= retry_q + 8'd1;
        end
    end

    assign o_retry_cnt = retry_q;
`endif

endmodule

// File: tb/tb_tlk2711_link_ctrl.sv
// Scoreboard bench for tlk2711_link_ctrl: the stimulus pushes the expected output
// snapshot and cycle of every output change; the monitor pops one per observed change.
`timescale 1ns/1ps
module tb_tlk2711_link_ctrl;

    logic       clk;
    logic       rst;
    logic       i_start;
    logic       i_stop;
    logic [2:0] i_mode;
    logic       i_rx_comma;
    logic       o_enable, o_lckrefn, o_loopen, o_prbsen, o_testen;
    logic       o_tx_sel, o_link_up, o_busy, o_err, o_stop_ack;
    logic [2:0] o_state;
`ifdef TLK2711_LINK_RETRY_CNT_EN
    logic [7:0] o_retry_cnt;
`endif

    tlk2711_link_ctrl dut (
        .clk         (clk),
        .rst         (rst),
        .i_start     (i_start),
        .i_stop      (i_stop),
        .i_mode      (i_mode),
        .i_rx_comma  (i_rx_comma),
        .o_enable    (o_enable),
        .o_lckrefn   (o_lckrefn),
        .o_loopen    (o_loopen),
        .o_prbsen    (o_prbsen),
        .o_testen    (o_testen),
        .o_tx_sel    (o_tx_sel),
        .o_link_up   (o_link_up),
        .o_busy      (o_busy),
        .o_err       (o_err),
        .o_stop_ack  (o_stop_ack),
`ifdef TLK2711_LINK_RETRY_CNT_EN
        .o_retry_cnt (o_retry_cnt),
`endif
        .o_state     (o_state)
    );

    int checks = 0;
    int errors = 0;
    int cyc = 0;

    int          exp_cyc[$];
    logic [12:0] exp_vec[$];

    logic [12:0] outv;
    assign outv = {o_state, o_enable, o_lckrefn, o_loopen, o_prbsen, o_testen,
                   o_tx_sel, o_link_up, o_busy, o_err, o_stop_ack};

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    always @(posedge clk) cyc <= cyc + 1;

    function automatic logic [12:0] vec(input logic [2:0] st, input logic en, input logic lck,
                                        input logic lp, input logic pr, input logic tx,
                                        input logic lk, input logic bs, input logic er,
                                        input logic ak);
        return {st, en, lck, lp, pr, 1'b0, tx, lk, bs, er, ak};
    endfunction

    task automatic exp_ev(input int c, input logic [12:0] v);
        exp_cyc.push_back(c);
        exp_vec.push_back(v);
    endtask

    // Advance to 1 ns after the posedge that starts cycle c.
    task automatic at(input int c);
        while (cyc < c) begin
            @(posedge clk);
            #1;
        end
    endtask

    // Monitor: every change of the output vector must match the next expected event.
    initial begin
        logic [12:0] prev, cur, ev;
        int ec;
        prev = '0;
        forever begin
            @(negedge clk);
            cur = outv;
            if (cur !== prev) begin
                checks++;
                if (exp_cyc.size() == 0) begin
                    errors++;
                    $display("FAIL unexpected_change: cycle %0d outputs %h, none expected",
                             cyc, cur);
                end else begin
                    ec = exp_cyc.pop_front();
                    ev = exp_vec.pop_front();
                    if (cyc != ec || cur !== ev) begin
                        errors++;
                        $display("FAIL event: got %h at cycle %0d, required %h at cycle %0d",
                                 cur, cyc, ev, ec);
                    end
                end
                prev = cur;
            end
        end
    end

    initial begin
        #20000;
        $display("FAIL watchdog: simulation did not complete at cycle %0d", cyc);
        $fatal(1, "watchdog");
    end

    initial begin
        i_start    = 1'b0;
        i_stop     = 1'b0;
        i_mode     = 3'd0;
        i_rx_comma = 1'b0;
        rst        = 1'b0;
        #1 rst = 1'b1;

        at(2);
        checks++;
        if (outv !== 13'd0) begin
            errors++;
            $display("FAIL reset_state: got %h, required 0", outv);
        end
        at(3);
        rst = 1'b0;

        // Normal bring-up, mode 0, commas from SYNC entry.
        at(10);
        i_mode = 3'd0; i_start = 1'b1;
        exp_ev(12, vec(3'd1, 1, 0, 0, 0, 0, 0, 1, 0, 0));
        exp_ev(20, vec(3'd2, 1, 1, 0, 0, 0, 0, 1, 0, 0));
        exp_ev(36, vec(3'd3, 1, 1, 0, 0, 0, 0, 1, 0, 0));
        exp_ev(41, vec(3'd4, 1, 1, 0, 0, 1, 1, 1, 0, 0));
        at(11); i_start = 1'b0;
        at(36); i_rx_comma = 1'b1;
        // Start edge in RUN is ignored.
        at(50); i_start = 1'b1;
        at(51); i_start = 1'b0;
        // Stop from RUN; a second stop edge during STOP is ignored.
        at(60);
        i_stop = 1'b1;
        exp_ev(62, vec(3'd5, 1, 1, 0, 0, 0, 0, 1, 0, 0));
        exp_ev(77, vec(3'd5, 1, 1, 0, 0, 0, 0, 1, 0, 1));
        exp_ev(78, 13'd0);
        at(61); i_stop = 1'b0;
        at(62); i_rx_comma = 1'b0;
        at(65); i_stop = 1'b1;
        at(66); i_stop = 1'b0;

        // Invalid mode 5.
        at(90);
        i_mode = 3'd5; i_start = 1'b1;
        exp_ev(92, vec(3'd0, 0, 0, 0, 0, 0, 0, 0, 1, 0));
        exp_ev(93, 13'd0);
        at(91); i_start = 1'b0;

        // Stop and start together in IDLE: stop acknowledged, start ignored.
        at(100);
        i_mode = 3'd0; i_start = 1'b1; i_stop = 1'b1;
        exp_ev(102, vec(3'd0, 0, 0, 0, 0, 0, 0, 0, 0, 1));
        exp_ev(103, 13'd0);
        at(101); i_start = 1'b0; i_stop = 1'b0;

        // Sync retry with toggling comma, then stop from the second LOCK.
        for (int c = 110; c <= 206; c++) begin
            at(c);
            i_rx_comma = (c % 2 == 1);
            if (c == 110) begin
                i_mode = 3'd0; i_start = 1'b1;
                exp_ev(112, vec(3'd1, 1, 0, 0, 0, 0, 0, 1, 0, 0));
                exp_ev(120, vec(3'd2, 1, 1, 0, 0, 0, 0, 1, 0, 0));
                exp_ev(136, vec(3'd3, 1, 1, 0, 0, 0, 0, 1, 0, 0));
                exp_ev(200, vec(3'd2, 1, 1, 0, 0, 0, 0, 1, 1, 0));
                exp_ev(201, vec(3'd2, 1, 1, 0, 0, 0, 0, 1, 0, 0));
            end
            if (c == 111) i_start = 1'b0;
`ifdef TLK2711_LINK_RETRY_CNT_EN
            if (c == 202) begin
                checks++;
                if (o_retry_cnt !== 8'd1) begin
                    errors++;
                    $display("FAIL retry_cnt: got %0d, required 1", o_retry_cnt);
                end
            end
`endif
            if (c == 205) begin
                i_stop = 1'b1;
                exp_ev(207, vec(3'd5, 1, 1, 0, 0, 0, 0, 1, 0, 0));
                exp_ev(222, vec(3'd5, 1, 1, 0, 0, 0, 0, 1, 0, 1));
                exp_ev(223, 13'd0);
            end
            if (c == 206) i_stop = 1'b0;
        end
        i_rx_comma = 1'b0;

        // PRBS: LOCK goes straight to RUN, tx_sel stays low.
        at(240);
        i_mode = 3'd2; i_start = 1'b1;
        exp_ev(242, vec(3'd1, 1, 0, 0, 0, 0, 0, 1, 0, 0));
        exp_ev(250, vec(3'd2, 1, 1, 0, 1, 0, 0, 1, 0, 0));
        exp_ev(266, vec(3'd4, 1, 1, 0, 1, 0, 1, 1, 0, 0));
        at(241); i_start = 1'b0;
`ifdef TLK2711_LINK_RETRY_CNT_EN
        at(245);
        checks++;
        if (o_retry_cnt !== 8'd0) begin
            errors++;
            $display("FAIL retry_clear: got %0d, required 0", o_retry_cnt);
        end
`endif
        at(280);
        i_stop = 1'b1;
        exp_ev(282, vec(3'd5, 1, 1, 0, 1, 0, 0, 1, 0, 0));
        exp_ev(297, vec(3'd5, 1, 1, 0, 1, 0, 0, 1, 0, 1));
        exp_ev(298, 13'd0);
        at(281); i_stop = 1'b0;

        // Asynchronous reset during SYNC, then a fresh bring-up.
        at(320);
        i_mode = 3'd0; i_start = 1'b1;
        exp_ev(322, vec(3'd1, 1, 0, 0, 0, 0, 0, 1, 0, 0));
        exp_ev(330, vec(3'd2, 1, 1, 0, 0, 0, 0, 1, 0, 0));
        exp_ev(346, vec(3'd3, 1, 1, 0, 0, 0, 0, 1, 0, 0));
        at(321); i_start = 1'b0;
        at(350);
        exp_ev(350, 13'd0);
        rst = 1'b1;
        #1;
        checks++;
        if (outv !== 13'd0) begin
            errors++;
            $display("FAIL async_reset: got %h, required 0", outv);
        end
        at(353); rst = 1'b0;
        at(360);
        i_start = 1'b1;
        exp_ev(362, vec(3'd1, 1, 0, 0, 0, 0, 0, 1, 0, 0));
        exp_ev(370, vec(3'd2, 1, 1, 0, 0, 0, 0, 1, 0, 0));
        exp_ev(386, vec(3'd3, 1, 1, 0, 0, 0, 0, 1, 0, 0));
        exp_ev(391, vec(3'd4, 1, 1, 0, 0, 1, 1, 1, 0, 0));
        at(361); i_start = 1'b0;
        at(386); i_rx_comma = 1'b1;
        at(400);
        i_stop = 1'b1;
        exp_ev(402, vec(3'd5, 1, 1, 0, 0, 0, 0, 1, 0, 0));
        exp_ev(417, vec(3'd5, 1, 1, 0, 0, 0, 0, 1, 0, 1));
        exp_ev(418, 13'd0);
        at(401); i_stop = 1'b0;
        at(402); i_rx_comma = 1'b0;

        at(430);
        while (exp_cyc.size() != 0) begin
            checks++;
            errors++;
            $display("FAIL missing_event: cycle %0d outputs %h never observed",
                     exp_cyc.pop_front(), exp_vec.pop_front());
        end
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
